pipe_stage_skid: RTL

- Parametrised successor to the 32-bit enabled pipeline register between CPU stages.
- Replaces the single "control" enable with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Registers keep full throughput with registered in_ready, so stalls do not form long combinational ready chains.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage WIDTH.

---
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from the state register, so downstream stalls
// never turn into a combinational ready path. flush empties the stage on
// the next edge and takes priority over everything else.
// Optional: define PIPE_STAGE_STALL_CNT_EN to add a saturating stall_cnt
// output that counts cycles in which out_data is held by out_ready=0.
//
// state | meaning
// EMPTY | no word held, out_valid=0
// FULL  | main register holds the next word to emit
// SKID  | main and skid both hold words, skid is emitted after main
module pipe_stage_skid #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_SKID);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Next state and register load selects; flush overrides any transfer.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (emit) begin
            state_nxt = ST_EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = ST_SKID;
          end
        end
        ST_SKID: begin
          if (emit) begin
            load_main_skid = 1'b1;
            state_nxt      = ST_FULL;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Main and skid data registers; flushed contents are left stale and masked by out_valid.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_data  <= RESET_VALUE;
      skid_data <= {WIDTH{1'b0}};
    end else begin
      if (load_main_in) begin
        out_data <= in_data;
      end else if (load_main_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of held-output cycles; flush deliberately leaves it alone.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  // CNT_W stays in the parameter list so instantiations are identical in both builds.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
